// File: rtl/subdiv_pkg.sv
// Shared constants and state encoding for the two-requester RAM arbiter.
package subdiv_pkg;

    localparam int RAM_AW  = 9;
    localparam int RAM_DW  = 32;
    localparam int NUM_REQ = 2;
    localparam int BE_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter with bounded bursts and a 2-stage read-valid tag.
// Define ARB_ROUND_ROBIN_EN to alternate tie winners from IDLE; otherwise requester 0 wins ties.
module ram_arbiter
    import subdiv_pkg::*;
#(
    parameter int AW        = RAM_AW,
    parameter int DW        = RAM_DW,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*AW-1:0]   addr,
    input  logic [NUM_REQ*BE_W-1:0] we,
    input  logic [NUM_REQ*DW-1:0]   wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rvalid,
    output logic [DW-1:0]           rdata,
    output logic                    RAM_EN,
    output logic [AW-1:0]           RAM_A,
    output logic [BE_W-1:0]         RAM_WE,
    output logic [DW-1:0]           RAM_Di,
    input  logic [DW-1:0]           RAM_Do
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    logic [AW-1:0]   addr_slice  [NUM_REQ];
    logic [BE_W-1:0] we_slice    [NUM_REQ];
    logic [DW-1:0]   wdata_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_slice[gi]  = addr[gi*AW +: AW];
            assign we_slice[gi]    = we[gi*BE_W +: BE_W];
            assign wdata_slice[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    arb_state_t           state_reg;
    logic [NUM_REQ-1:0]   gnt_reg;
    logic [CNT_W-1:0]     burst_cnt_reg;
    logic                 ram_en_reg;
    logic [AW-1:0]        ram_a_reg;
    logic [BE_W-1:0]      ram_we_reg;
    logic [DW-1:0]        ram_di_reg;
    logic [NUM_REQ-1:0]   tag1_reg;
    logic [NUM_REQ-1:0]   tag2_reg;

    logic owner_idx;
    logic other_idx;
    logic owning;
    logic at_limit;
    logic forced;
    logic accept;
    logic rd_accept;
    logic idle_pick;

    assign owner_idx = (state_reg == OWN1);
    assign other_idx = ~owner_idx;
    assign owning    = (state_reg != IDLE);
    assign at_limit  = (burst_cnt_reg == BURST_LIMIT);
    // A full burst yields to a waiting peer even if the owner still requests.
    assign forced    = owning && at_limit && req[other_idx];
    assign accept    = owning && !forced && req[owner_idx];
    assign rd_accept = accept && (we_slice[owner_idx] == '0);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_reg;
    assign idle_pick = (&req) ? ~last_owner_reg : req[1];
`else
    assign idle_pick = ~req[0];
`endif

    logic move;
    logic to_own;
    logic new_owner;

    always_comb begin
        move      = 1'b0;
        to_own    = 1'b0;
        new_owner = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    move      = 1'b1;
                    to_own    = 1'b1;
                    new_owner = idle_pick;
                end
            end
            default: begin
                if (forced || (!accept && req[other_idx])) begin
                    move      = 1'b1;
                    to_own    = 1'b1;
                    new_owner = other_idx;
                end else if (!accept) begin
                    move = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            burst_cnt_reg <= '0;
        end else if (move) begin
            burst_cnt_reg <= '0;
            if (to_own) begin
                state_reg <= new_owner ? OWN1 : OWN0;
                gnt_reg   <= owner_onehot(new_owner);
            end else begin
                state_reg <= IDLE;
                gnt_reg   <= '0;
            end
        end else if (accept && !at_limit) begin
            burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= 1'b1;
        end else if (move && to_own) begin
            last_owner_reg <= new_owner;
        end
    end
`endif

    // RAM port registers and read tag pipeline; reset also kills in-flight read tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en_reg <= 1'b0;
            ram_a_reg  <= '0;
            ram_we_reg <= '0;
            ram_di_reg <= '0;
            tag1_reg   <= '0;
            tag2_reg   <= '0;
        end else begin
            ram_en_reg <= accept;
            ram_we_reg <= accept ? we_slice[owner_idx] : '0;
            if (accept) begin
                ram_a_reg  <= addr_slice[owner_idx];
                ram_di_reg <= wdata_slice[owner_idx];
            end
            tag1_reg <= rd_accept ? owner_onehot(owner_idx) : '0;
            tag2_reg <= tag1_reg;
        end
    end

    assign gnt    = gnt_reg;
    assign rvalid = tag2_reg;
    assign rdata  = RAM_Do;
    assign RAM_EN = ram_en_reg;
    assign RAM_A  = ram_a_reg;
    assign RAM_WE = ram_we_reg;
    assign RAM_Di = ram_di_reg;

endmodule
